// File: rtl/rect_reg_arbiter.sv
// rect_reg_arbiter: shares the rectangle channel registers $4000-$4003
// between the UART host and the sequencer, one buffered write at a time.
module rect_reg_arbiter #(
    parameter bit          SYNC_COMMIT   = 1'b1,
    parameter bit          HOST_PRIORITY = 1'b0,
    parameter int unsigned GAP_CYCLES    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable_240hz,
    input  logic        host_req,
    input  logic [31:0] host_data,
    input  logic        seq_req,
    input  logic [31:0] seq_data,
    output logic [7:0]  reg_4000,
    output logic [7:0]  reg_4001,
    output logic [7:0]  reg_4002,
    output logic [7:0]  reg_4003,
    output logic        reg_change,
    output logic        host_grant,
    output logic        seq_grant,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        COMMIT,
        GAP
    } state_t;

    localparam logic [7:0]  GAP_LAST  = 8'(GAP_CYCLES - 1);
    localparam logic [31:0] REGS_INIT = 32'h0000_0030;

    state_t      state_q, state_d;
    logic [7:0]  gap_q, gap_d;
    logic        host_pend_q, host_pend_d;
    logic        seq_pend_q, seq_pend_d;
    logic [31:0] host_shd_q, host_shd_d;
    logic [31:0] seq_shd_q, seq_shd_d;
    logic        last_seq_q, last_seq_d;
    logic [31:0] regs_q, regs_d;
    logic        chg_q, chg_d;
    logic        hg_q, hg_d;
    logic        sg_q, sg_d;
    logic        busy_q, busy_d;
    logic        win_seq, win_host;

    // Seq wins when alone, or on a round-robin tie after a host grant.
    assign win_seq  = seq_pend_q &&
                      (!host_pend_q || (!HOST_PRIORITY && !last_seq_q));
    assign win_host = host_pend_q && !win_seq;

    assign reg_4000   = regs_q[7:0];
    assign reg_4001   = regs_q[15:8];
    assign reg_4002   = regs_q[23:16];
    assign reg_4003   = regs_q[31:24];
    assign reg_change = chg_q;
    assign host_grant = hg_q;
    assign seq_grant  = sg_q;
    assign busy       = busy_q;

    // Next state, commit datapath and shadow capture.
    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        host_pend_d = host_pend_q;
        seq_pend_d  = seq_pend_q;
        host_shd_d  = host_shd_q;
        seq_shd_d   = seq_shd_q;
        last_seq_d  = last_seq_q;
        regs_d      = regs_q;
        chg_d       = 1'b0;
        hg_d        = 1'b0;
        sg_d        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (host_pend_q || seq_pend_q || host_req || seq_req)
                    state_d = ARMED;
            end
            ARMED: begin
                if (!SYNC_COMMIT || enable_240hz) begin
                    state_d = COMMIT;
                    gap_d   = 8'd0;
                end
            end
            COMMIT: begin
                chg_d = win_host || win_seq;
                hg_d  = win_host;
                sg_d  = win_seq;
                if (win_seq) begin
                    regs_d     = seq_shd_q;
                    seq_pend_d = 1'b0;
                    last_seq_d = 1'b1;
                end else if (win_host) begin
                    regs_d      = host_shd_q;
                    host_pend_d = 1'b0;
                    last_seq_d  = 1'b0;
                end
                state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
            GAP: begin
                if (gap_q == GAP_LAST)
                    state_d = IDLE;
                else
                    gap_d = gap_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
        // A same-cycle request re-arms pending after its own commit.
        if (host_req) begin
            host_shd_d  = host_data;
            host_pend_d = 1'b1;
        end
        if (seq_req) begin
            seq_shd_d  = seq_data;
            seq_pend_d = 1'b1;
        end
        busy_d = host_pend_d || seq_pend_d || (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            gap_q       <= 8'd0;
            host_pend_q <= 1'b0;
            seq_pend_q  <= 1'b0;
            host_shd_q  <= 32'd0;
            seq_shd_q   <= 32'd0;
            last_seq_q  <= 1'b1;
            regs_q      <= REGS_INIT;
            chg_q       <= 1'b0;
            hg_q        <= 1'b0;
            sg_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            host_pend_q <= host_pend_d;
            seq_pend_q  <= seq_pend_d;
            host_shd_q  <= host_shd_d;
            seq_shd_q   <= seq_shd_d;
            last_seq_q  <= last_seq_d;
            regs_q      <= regs_d;
            chg_q       <= chg_d;
            hg_q        <= hg_d;
            sg_q        <= sg_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_rect_reg_arbiter.sv
// tb_rect_reg_arbiter: four configurations of the arbiter on shared
// stimulus, checked against a timestamp-level reference model.
module tb_rect_reg_arbiter;

    localparam int ND = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, tick, hreq, sreq;
    logic [31:0] hdat, sdat;
    logic [ND-1:0][7:0] r0, r1, r2, r3;
    logic [ND-1:0]      chg, hg, sg, bsy;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        rect_reg_arbiter #(
            .SYNC_COMMIT  (g == 1),
            .HOST_PRIORITY(g == 2),
            .GAP_CYCLES   ((g == 3) ? 0 : 4)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .enable_240hz(tick),
            .host_req    (hreq),
            .host_data   (hdat),
            .seq_req     (sreq),
            .seq_data    (sdat),
            .reg_4000    (r0[g]),
            .reg_4001    (r1[g]),
            .reg_4002    (r2[g]),
            .reg_4003    (r3[g]),
            .reg_change  (chg[g]),
            .host_grant  (hg[g]),
            .seq_grant   (sg[g]),
            .busy        (bsy[g])
        );
    end

    bit msync [ND] = '{1'b0, 1'b1, 1'b0, 1'b0};
    bit mhp   [ND] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int mgap  [ND] = '{4, 4, 4, 0};

    typedef struct {
        int          id;
        int          t;
        bit          w;
        logic [31:0] d;
    } ev_t;

    ev_t exq[$];
    int  cyc;
    int  nvec = 0;
    int  nmis = 0;

    bit          pend_h [ND];
    bit          pend_s [ND];
    logic [31:0] sh_h   [ND];
    logic [31:0] sh_s   [ND];
    bit          last_s [ND];
    int          free_at[ND];
    int          arm_t  [ND];
    int          com_t  [ND];

    function automatic logic [31:0] regs(input int k);
        return {r3[k], r2[k], r1[k], r0[k]};
    endfunction

    task automatic chk(input string nm, input int k,
                       input logic [63:0] a, input logic [63:0] e);
        nvec++;
        if (a !== e) begin
            nmis++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h",
                     nm, k, cyc, a, e);
        end
    endtask

    // Reference: when the block may look, when it may commit, who wins.
    task automatic model_step(input int k);
        ev_t e;
        if (reset) begin
            pend_h[k]  = 1'b0;
            pend_s[k]  = 1'b0;
            sh_h[k]    = '0;
            sh_s[k]    = '0;
            last_s[k]  = 1'b1;
            arm_t[k]   = -1;
            com_t[k]   = -1;
            free_at[k] = cyc + 1;
            return;
        end
        if (com_t[k] == cyc) begin
            if (pend_h[k] && pend_s[k])
                e.w = mhp[k] ? 1'b0 : !last_s[k];
            else
                e.w = pend_s[k];
            e.id = k;
            e.t  = cyc + 1;
            e.d  = e.w ? sh_s[k] : sh_h[k];
            exq.push_back(e);
            if (e.w) pend_s[k] = 1'b0;
            else     pend_h[k] = 1'b0;
            last_s[k]  = e.w;
            com_t[k]   = -1;
            free_at[k] = cyc + 1 + mgap[k];
        end else if (arm_t[k] >= 0 && cyc >= arm_t[k] &&
                     (!msync[k] || tick)) begin
            com_t[k] = cyc + 1;
            arm_t[k] = -1;
        end else if (arm_t[k] < 0 && com_t[k] < 0 && cyc >= free_at[k] &&
                     (pend_h[k] || pend_s[k] || hreq || sreq)) begin
            arm_t[k] = cyc + 1;
        end
        if (hreq) begin
            sh_h[k]   = hdat;
            pend_h[k] = 1'b1;
        end
        if (sreq) begin
            sh_s[k]   = sdat;
            pend_s[k] = 1'b1;
        end
    endtask

    // Model: consumes each cycle's inputs at the clock edge.
    initial begin
        cyc = 0;
        for (int k = 0; k < ND; k++) begin
            arm_t[k] = -1;
            com_t[k] = -1;
            free_at[k] = 0;
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < ND; k++) model_step(k);
            cyc++;
        end
    end

    // Monitor: pops expected commits when a strobe appears.
    initial begin
        bit          live;
        logic [31:0] cur [ND];
        int          mi;
        int          idx;
        ev_t         e;
        live = 1'b0;
        forever begin
            @(negedge clk);
            if (live) begin
                mi = 0;
                while (mi < exq.size()) begin
                    if (exq[mi].t < cyc) begin
                        chk("commit_missing", exq[mi].id, 64'(exq[mi].t), 64'(-1));
                        exq.delete(mi);
                    end else begin
                        mi++;
                    end
                end
                for (int k = 0; k < ND; k++) begin
                    if (chg[k] || hg[k] || sg[k]) begin
                        idx = -1;
                        for (int i = 0; i < exq.size(); i++)
                            if (idx < 0 && exq[i].id == k) idx = i;
                        if (idx < 0) begin
                            chk("commit_unexpected", k,
                                {29'd0, chg[k], hg[k], sg[k], regs(k)}, 64'd0);
                        end else begin
                            e = exq[idx];
                            exq.delete(idx);
                            chk("commit_cycle", k, 64'(cyc), 64'(e.t));
                            chk("commit_value", k,
                                {29'd0, chg[k], hg[k], sg[k], regs(k)},
                                {29'd0, 1'b1, !e.w, e.w, e.d});
                            cur[k] = e.d;
                        end
                    end else begin
                        chk("regs_hold", k, 64'(regs(k)), 64'(cur[k]));
                    end
                end
            end
            if (reset) begin
                live = 1'b1;
                for (int k = 0; k < ND; k++) cur[k] = 32'h0000_0030;
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
        hreq = 1'b0;
        sreq = 1'b0;
        tick = 1'b0;
    endtask

    // Stimulus: directed scenarios, then random traffic and a drain.
    initial begin
        reset = 1'b1;
        tick  = 1'b0;
        hreq  = 1'b0;
        sreq  = 1'b0;
        hdat  = '0;
        sdat  = '0;
        nxt(); nxt(); nxt();
        for (int k = 0; k < ND; k++) begin
            chk("rst_regs", k, 64'(regs(k)), 64'h30);
            chk("rst_busy", k, 64'(bsy[k]), 64'd0);
            chk("rst_strobe", k, {61'd0, chg[k], hg[k], sg[k]}, 64'd0);
        end
        hreq = 1'b1; hdat = 32'hDEADBEEF;
        sreq = 1'b1; sdat = 32'h01020304;
        nxt();
        reset = 1'b0;
        repeat (20) nxt();
        for (int k = 0; k < ND; k++)
            chk("rst_req_dropped", k, 64'(bsy[k]), 64'd0);

        hreq = 1'b1; hdat = 32'h8F1234BF;
        nxt();
        chk("host_busy", 0, 64'(bsy[0]), 64'd1);
        nxt();
        chk("host_early", 0, 64'(chg[0]), 64'd0);
        nxt();
        for (int k = 0; k < ND; k++) begin
            if (k != 1)
                chk("host_latency", k, {29'd0, chg[k], hg[k], sg[k], regs(k)},
                    {29'd0, 3'b110, 32'h8F1234BF});
        end
        repeat (10) nxt();
        tick = 1'b1;
        nxt();
        repeat (15) nxt();

        sreq = 1'b1; sdat = 32'hA5C3_0F11;
        repeat (35) nxt();
        tick = 1'b1;
        nxt();
        chk("tick_early", 1, 64'(chg[1]), 64'd0);
        nxt();
        chk("tick_commit", 1, {29'd0, chg[1], hg[1], sg[1], regs(1)},
            {29'd0, 3'b101, 32'hA5C3_0F11});
        repeat (10) nxt();

        hreq = 1'b1; hdat = 32'h1111_2222;
        sreq = 1'b1; sdat = 32'h3333_4444;
        for (int i = 1; i <= 14; i++) begin
            nxt();
            if (i == 3)
                chk("rr_first", 0, {61'd0, chg[0], hg[0], sg[0]}, 64'b110);
            if (i == 10)
                chk("rr_second", 0, {61'd0, chg[0], hg[0], sg[0]}, 64'b101);
            if (i == 13)
                chk("rr_busy_gap", 0, 64'(bsy[0]), 64'd1);
            if (i == 14)
                chk("rr_busy_drop", 0, 64'(bsy[0]), 64'd0);
        end
        for (int i = 0; i < 30; i++) begin
            tick = (i % 6 == 0);
            nxt();
        end

        hreq = 1'b1; hdat = 32'hAAAA_0001;
        nxt();
        hreq = 1'b1; hdat = 32'hBBBB_0002;
        nxt();
        hreq = 1'b1; hdat = 32'hCCCC_0003;
        nxt();
        chk("overwrite_b", 0, {29'd0, chg[0], hg[0], sg[0], regs(0)},
            {29'd0, 3'b110, 32'hBBBB_0002});
        repeat (7) nxt();
        chk("same_cycle_c", 0, {29'd0, chg[0], hg[0], sg[0], regs(0)},
            {29'd0, 3'b110, 32'hCCCC_0003});
        for (int i = 0; i < 30; i++) begin
            tick = (i % 5 == 0);
            nxt();
        end

        sreq = 1'b1; sdat = 32'h5EC0_5EC0;
        for (int i = 0; i < 60; i++) begin
            if (i % 10 == 0) begin
                hreq = 1'b1;
                hdat = $urandom;
            end
            tick = (i % 5 == 0);
            nxt();
        end

        for (int i = 0; i < 1500; i++) begin
            hreq  = ($urandom_range(0, 9) == 0);
            hdat  = $urandom;
            sreq  = ($urandom_range(0, 9) == 0);
            sdat  = $urandom;
            tick  = ($urandom_range(0, 5) == 0);
            reset = ($urandom_range(0, 399) == 0);
            nxt();
        end
        reset = 1'b0;
        for (int i = 0; i < 48; i++) begin
            tick = (i % 4 == 0);
            nxt();
        end
        repeat (4) nxt();
        for (int k = 0; k < ND; k++)
            chk("drain_busy", k, 64'(bsy[k]), 64'd0);
        chk("drain_queue", 0, 64'(exq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
